// File: rtl/vx_l1_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// vx_l1_mem_arb_pkg
// Shared cache-hierarchy constants for the L1 -> L2 memory arbiter:
//   - which optional L1 caches (tex / raster / rop) are present
//   - NUM_L1_OUTPUTS, L1_MEM_TAG_WIDTH, L2_TAG_WIDTH
//   - L1 source indices (the value appended to the L2 tag for each L1 side)
//   - PERF_CTR_BITS for the optional stall counter
// -----------------------------------------------------------------------------
package vx_l1_mem_arb_pkg;

  localparam int L1_TEX_ENABLE    = 1;
  localparam int L1_RASTER_ENABLE = 1;
  localparam int L1_ROP_ENABLE    = 1;

  // icache + dcache are always present, the rest follow their enables
  localparam int NUM_L1_OUTPUTS = 2 + L1_TEX_ENABLE + L1_RASTER_ENABLE + L1_ROP_ENABLE;

  localparam int L1_MEM_TAG_WIDTH = 16;

  // Bits needed to encode an index, never less than one so ports stay legal
  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Only the true log2 is appended: a single source adds nothing to the tag
  localparam int L2_TAG_WIDTH = L1_MEM_TAG_WIDTH + $clog2(NUM_L1_OUTPUTS);

  // Source indices, optional caches numbered in enable order
  localparam int L1_SRC_ICACHE = 0;
  localparam int L1_SRC_DCACHE = 1;
  localparam int L1_SRC_TCACHE = 2;
  localparam int L1_SRC_RCACHE = 2 + L1_TEX_ENABLE;
  localparam int L1_SRC_OCACHE = 2 + L1_TEX_ENABLE + L1_RASTER_ENABLE;

  localparam int PERF_CTR_BITS = 44;

endpackage

// File: rtl/vx_l1_mem_arb_rr_picker.sv
// -----------------------------------------------------------------------------
// vx_l1_mem_arb_rr_picker
// Combinational masked round-robin picker. Sources at or above rr_ptr are
// tried first (lowest index wins); if none of them is valid, the lowest valid
// source overall wins, which is the wrap-around part of the scan.
// Ports:
//   valid  [NUM_REQS]  request lines
//   rr_ptr [SEL_BITS]  first index to consider
//   grant  [NUM_REQS]  one-hot winner (zero when nothing valid)
//   index  [SEL_BITS]  binary winner index
//   found              any source valid
// -----------------------------------------------------------------------------
module vx_l1_mem_arb_rr_picker #(
  parameter int NUM_REQS = 5,
  parameter int SEL_BITS = 3
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [SEL_BITS-1:0] rr_ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [SEL_BITS-1:0] index,
  output logic                found
);

  logic [NUM_REQS-1:0] upper;
  logic [NUM_REQS-1:0] cand;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_mask
    assign upper[gi] = valid[gi] && (SEL_BITS'(gi) >= rr_ptr);
  end

  always_comb begin
    cand  = (|upper) ? upper : valid;
    grant = '0;
    index = '0;
    // descending scan: the last hit written is the lowest candidate index
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = SEL_BITS'(i);
      end
    end
    found = |valid;
  end

endmodule

// File: rtl/vx_l1_mem_arb.sv
// -----------------------------------------------------------------------------
// vx_l1_mem_arb
// Shares the single L2 request port among NUM_REQS L1 memory sides.
//   Requests : round-robin grant, winner index appended in the tag LSBs,
//              2-entry FIFO toward L2 (req_ready_in depends only on
//              registered fullness, never on req_ready_out).
//   Responses: combinational demux by the tag LSBs; an index with no source
//              behind it is accepted and dropped.
// Ports: clk, reset (sync, active-high); req_*_in / req_ready_in per source;
//   req_*_out / req_ready_out toward L2; rsp_*_in / rsp_ready_in from L2;
//   rsp_*_out / rsp_ready_out per source.
// Optional: define VX_L1_MEM_ARB_PERF_EN to add perf_stalls, a saturating
//   count of cycles with a valid source and no grant, or an unaccepted output.
// -----------------------------------------------------------------------------
module vx_l1_mem_arb
  import vx_l1_mem_arb_pkg::*;
#(
  parameter int NUM_REQS     = NUM_L1_OUTPUTS,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_SIZE    = 64,
  parameter int TAG_IN_WIDTH = L1_MEM_TAG_WIDTH,
  localparam int SEL_BITS      = up_clog2(NUM_REQS),
  localparam int SEL_LOG       = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_LOG,
  localparam int DATA_WIDTH    = 8 * DATA_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS-1:0]              req_rw_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_in,
  output logic                             req_valid_out,
  output logic                             req_rw_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic [DATA_SIZE-1:0]             req_byteen_out,
  output logic [DATA_WIDTH-1:0]            req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic                             req_ready_out,
  input  logic                             rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]            rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
  output logic                             rsp_ready_in,
  output logic [NUM_REQS-1:0]              rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_tag_out,
  input  logic [NUM_REQS-1:0]              rsp_ready_out
`ifdef VX_L1_MEM_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]         perf_stalls
`endif
);

  typedef struct packed {
    logic                     rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_SIZE-1:0]     byteen;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_t;

  // ---------------- arbitration ----------------
  logic [SEL_BITS-1:0] rr_ptr_reg;
  logic [NUM_REQS-1:0] grant;
  logic [SEL_BITS-1:0] winner;
  logic                found;
  logic                full;
  logic                push;
  logic                pop;
  req_t                push_entry;
  logic [TAG_IN_WIDTH-1:0] win_tag;

  vx_l1_mem_arb_rr_picker #(
    .NUM_REQS (NUM_REQS),
    .SEL_BITS (SEL_BITS)
  ) u_picker (
    .valid  (req_valid_in),
    .rr_ptr (rr_ptr_reg),
    .grant  (grant),
    .index  (winner),
    .found  (found)
  );

  assign push         = found && !full && !reset;
  assign req_ready_in = (full || reset) ? '0 : grant;

  // one-hot AND-OR select of the winner's payload
  always_comb begin
    push_entry = '0;
    win_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        push_entry.rw     = req_rw_in[i];
        push_entry.addr   = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        push_entry.byteen = req_byteen_in[i*DATA_SIZE +: DATA_SIZE];
        push_entry.data   = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        win_tag           = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
    push_entry.tag = TAG_OUT_WIDTH'(win_tag);
    if (SEL_LOG > 0) begin
      push_entry.tag = TAG_OUT_WIDTH'({win_tag, winner});
    end
  end

  // ---------------- 2-entry FIFO toward L2 ----------------
  req_t       buf_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  assign full = (count_reg == 2'd2);
  assign pop  = (count_reg != 2'd0) && req_ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
        rr_ptr_reg <= (32'(winner) == NUM_REQS - 1) ? '0 : winner + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

  // payload storage needs no reset; push is already blocked during reset
  always_ff @(posedge clk) begin
    if (push) begin
      buf_reg[wr_ptr_reg] <= push_entry;
    end
  end

  assign req_valid_out  = (count_reg != 2'd0);
  assign req_rw_out     = buf_reg[rd_ptr_reg].rw;
  assign req_addr_out   = buf_reg[rd_ptr_reg].addr;
  assign req_byteen_out = buf_reg[rd_ptr_reg].byteen;
  assign req_data_out   = buf_reg[rd_ptr_reg].data;
  assign req_tag_out    = buf_reg[rd_ptr_reg].tag;

  // ---------------- response demux ----------------
  logic [SEL_BITS-1:0]     rsp_sel;
  logic [TAG_IN_WIDTH-1:0] rsp_tag_body;
  logic [NUM_REQS-1:0]     rsp_hit;
  logic                    rsp_sel_ok;

  if (SEL_LOG == 0) begin : g_single
    assign rsp_sel      = '0;
    assign rsp_tag_body = rsp_tag_in;
  end else begin : g_multi
    assign rsp_sel      = rsp_tag_in[SEL_BITS-1:0];
    assign rsp_tag_body = rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];
  end

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rsp
    assign rsp_hit[gi]       = (rsp_sel == SEL_BITS'(gi));
    assign rsp_valid_out[gi] = rsp_valid_in && rsp_hit[gi] && !reset;
    assign rsp_data_out[gi*DATA_WIDTH +: DATA_WIDTH]       = rsp_data_in;
    assign rsp_tag_out[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH]    = rsp_tag_body;
  end

  assign rsp_sel_ok = |rsp_hit;
  // an index with no source behind it is swallowed so L2 never stalls on it
  assign rsp_ready_in = rsp_sel_ok ? |(rsp_ready_out & rsp_hit) : 1'b1;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && rsp_valid_in) begin
      assert (rsp_sel_ok)
      else $warning("L2 response routed to nonexistent source index %0d, dropped", rsp_sel);
    end
  end
`endif

`ifdef VX_L1_MEM_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stalls_reg;
  logic                     stall;

  assign stall = ((|req_valid_in) && !push) || (req_valid_out && !req_ready_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_reg <= '0;
    end else if (stall && !(&perf_stalls_reg)) begin
      perf_stalls_reg <= perf_stalls_reg + 1'b1;
    end
  end

  assign perf_stalls = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_vx_l1_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_vx_l1_mem_arb
// Directed bench for vx_l1_mem_arb with default parameters (5 sources,
// 16-bit input tags, 19-bit L2 tags). Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_vx_l1_mem_arb;
  import vx_l1_mem_arb_pkg::*;

  localparam int N   = 5;
  localparam int AW  = 26;
  localparam int DS  = 64;
  localparam int DW  = 8 * DS;
  localparam int TW  = 16;
  localparam int TOW = 19;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid_in;
  logic [N-1:0]    req_rw_in;
  logic [N*AW-1:0] req_addr_in;
  logic [N*DS-1:0] req_byteen_in;
  logic [N*DW-1:0] req_data_in;
  logic [N*TW-1:0] req_tag_in;
  logic [N-1:0]    req_ready_in;
  logic            req_valid_out;
  logic            req_rw_out;
  logic [AW-1:0]   req_addr_out;
  logic [DS-1:0]   req_byteen_out;
  logic [DW-1:0]   req_data_out;
  logic [TOW-1:0]  req_tag_out;
  logic            req_ready_out;
  logic            rsp_valid_in;
  logic [DW-1:0]   rsp_data_in;
  logic [TOW-1:0]  rsp_tag_in;
  logic            rsp_ready_in;
  logic [N-1:0]    rsp_valid_out;
  logic [N*DW-1:0] rsp_data_out;
  logic [N*TW-1:0] rsp_tag_out;
  logic [N-1:0]    rsp_ready_out;
`ifdef VX_L1_MEM_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stalls;
`endif

  int n_total = 0;
  int n_pass  = 0;

  vx_l1_mem_arb dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_in   (req_valid_in),
    .req_rw_in      (req_rw_in),
    .req_addr_in    (req_addr_in),
    .req_byteen_in  (req_byteen_in),
    .req_data_in    (req_data_in),
    .req_tag_in     (req_tag_in),
    .req_ready_in   (req_ready_in),
    .req_valid_out  (req_valid_out),
    .req_rw_out     (req_rw_out),
    .req_addr_out   (req_addr_out),
    .req_byteen_out (req_byteen_out),
    .req_data_out   (req_data_out),
    .req_tag_out    (req_tag_out),
    .req_ready_out  (req_ready_out),
    .rsp_valid_in   (rsp_valid_in),
    .rsp_data_in    (rsp_data_in),
    .rsp_tag_in     (rsp_tag_in),
    .rsp_ready_in   (rsp_ready_in),
    .rsp_valid_out  (rsp_valid_out),
    .rsp_data_out   (rsp_data_out),
    .rsp_tag_out    (rsp_tag_out),
    .rsp_ready_out  (rsp_ready_out)
`ifdef VX_L1_MEM_ARB_PERF_EN
    ,
    .perf_stalls    (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] tag, input logic [AW-1:0] addr, input logic rw);
    req_tag_in[i*TW +: TW]  = tag;
    req_addr_in[i*AW +: AW] = addr;
    req_rw_in[i]            = rw;
    req_byteen_in[i*DS +: DS] = {DS{1'b1}};
    req_data_in[i*DW +: DW]   = DW'(64'hD000 + 64'(i));
  endtask

  function automatic logic [63:0] l2tag(input logic [TW-1:0] t, input int s);
    logic [TOW-1:0] v;
    v = {t, 3'(s)};
    return 64'(v);
  endfunction

  initial begin
    reset = 1'b1;
    req_valid_in = '1; req_rw_in = '0; req_addr_in = '0; req_byteen_in = '0;
    req_data_in = '0; req_tag_in = '0; req_ready_out = 1'b1;
    rsp_valid_in = 1'b1; rsp_data_in = '0; rsp_tag_in = '0; rsp_ready_out = '1;

    // 1. reset: nothing granted or presented even with every source asking
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_req_valid_out", 64'(req_valid_out), 64'd0);
      chk("rst_req_ready_in",  64'(req_ready_in),  64'd0);
      chk("rst_rsp_valid_out", 64'(rsp_valid_out), 64'd0);
    end
`ifdef VX_L1_MEM_ARB_PERF_EN
    chk("rst_perf", 64'(perf_stalls), 64'd0);
`endif
    req_valid_in = '0;
    rsp_valid_in = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_req_valid_out", 64'(req_valid_out), 64'd0);

    // 2. sources 0,2,4: L2 sees 0,2,4,0 back to back
    for (int i = 0; i < N; i++) set_src(i, TW'(16'h100 + i), AW'(26'h1000 + i), 1'b0);
    req_valid_in = 5'b10101;
    #1;
    chk("rr_first_grant", 64'(req_ready_in), 64'b00001);
    begin
      int order[4] = '{0, 2, 4, 0};
      for (int k = 0; k < 4; k++) begin
        step();
        chk("rr_valid_out", 64'(req_valid_out), 64'd1);
        chk("rr_tag_out",   64'(req_tag_out),   l2tag(TW'(16'h100 + order[k]), order[k]));
        chk("rr_addr_out",  64'(req_addr_out),  64'h1000 + 64'(order[k]));
      end
    end
    req_valid_in = '0;
    step();
    chk("rr_drained", 64'(req_valid_out), 64'd0);

    // 3. src1 tag 0x1234 -> L2 tag 0x91A1, and its response comes back to src1
    set_src(1, 16'h1234, 26'h2AAAA, 1'b1);
    req_valid_in = 5'b00010;
    #1;
    chk("t3_grant", 64'(req_ready_in), 64'b00010);
    step();
    req_valid_in = '0;
    chk("t3_tag_out",  64'(req_tag_out),  64'h91A1);
    chk("t3_rw_out",   64'(req_rw_out),   64'd1);
    chk("t3_data_out", req_data_out[63:0], 64'hD001);
    step();
    chk("t3_drained", 64'(req_valid_out), 64'd0);
    rsp_valid_in = 1'b1; rsp_tag_in = 19'h91A1; rsp_data_in = DW'(64'hCAFE);
    #1;
    chk("t3_rsp_valid", 64'(rsp_valid_out), 64'b00010);
    chk("t3_rsp_tag",   64'(rsp_tag_out[1*TW +: TW]), 64'h1234);
    chk("t3_rsp_data",  rsp_data_out[1*DW +: 64], 64'hCAFE);
    chk("t3_rsp_ready", 64'(rsp_ready_in), 64'd1);

    // 5. response to src3 held off by its ready, then an unmapped index
    rsp_tag_in = {16'hBEEF, 3'd3}; rsp_ready_out = 5'b10111;
    #1;
    chk("t5_valid3",   64'(rsp_valid_out), 64'b01000);
    chk("t5_blocked",  64'(rsp_ready_in),  64'd0);
    step();
    chk("t5_blocked2", 64'(rsp_ready_in),  64'd0);
    rsp_ready_out = '1;
    #1;
    chk("t5_released", 64'(rsp_ready_in), 64'd1);
    chk("t5_tag3",     64'(rsp_tag_out[3*TW +: TW]), 64'hBEEF);
    rsp_tag_in = {16'h5555, 3'd6};
    #1;
    chk("t5_drop_valid", 64'(rsp_valid_out), 64'd0);
    chk("t5_drop_ready", 64'(rsp_ready_in),  64'd1);
    step();
    rsp_valid_in = 1'b0;

    // 4. L2 stalls 5 cycles with all sources valid (rr_ptr is 2 here)
    for (int i = 0; i < N; i++) set_src(i, TW'(16'h200 + i), AW'(26'h2000 + i), 1'b0);
    req_ready_out = 1'b0;
    req_valid_in  = '1;
    #1;
    chk("t4_grant2", 64'(req_ready_in), 64'b00100);
    step();
    chk("t4_valid_out", 64'(req_valid_out), 64'd1);
    chk("t4_grant3",    64'(req_ready_in),  64'b01000);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t4_full_ready", 64'(req_ready_in), 64'd0);
      chk("t4_hold_tag",   64'(req_tag_out),  l2tag(16'h202, 2));
      chk("t4_hold_addr",  64'(req_addr_out), 64'h2002);
    end
`ifdef VX_L1_MEM_ARB_PERF_EN
    chk("t4_perf_nonzero", 64'(perf_stalls != 0), 64'd1);
`endif
    req_ready_out = 1'b1;
    #1;
    chk("t4_no_comb_ready", 64'(req_ready_in), 64'd0);
    begin
      int order[3] = '{3, 4, 0};
      for (int k = 0; k < 3; k++) begin
        step();
        chk("t4_drain_tag", 64'(req_tag_out), l2tag(TW'(16'h200 + order[k]), order[k]));
      end
    end

    // 6. reset mid-stream with the buffer full
    req_ready_out = 1'b0;
    step();
    step();
    chk("t6_full_before", 64'(req_ready_in), 64'd0);
    reset = 1'b1;
    step();
    chk("t6_rst_valid_out", 64'(req_valid_out), 64'd0);
    chk("t6_rst_ready_in",  64'(req_ready_in),  64'd0);
`ifdef VX_L1_MEM_ARB_PERF_EN
    chk("t6_perf_cleared", 64'(perf_stalls), 64'd0);
`endif
    reset = 1'b0;
    req_valid_in = '0;
    req_ready_out = 1'b1;
    step();
    chk("t6_empty_after", 64'(req_valid_out), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
